fft32_bfly_sequencer: RTL
=========================

# fft32_bfly_sequencer

In-place 32-point radix-2 DIT FFT sequencer that sits directly upstream of the 32-bit combinational butterfly, feeding its operand and twiddle ports and capturing its results.
- Loads 32 complex samples in bit-reversed order into a local buffer.
- Drives 5 stages × 16 butterflies, one butterfly per clock.
- Streams the 32 results out in natural order over a valid/ready handshake.

## Interface
- TW_FRAC, 14: fractional bits of twiddle constants; twiddles are Q(31-TW_FRAC).TW_FRAC, sign-extended to 32 bits.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid / in_ready  in / out  1 / 1  input sample handshake.
- in_real, in_imag  in  32 / 32  input sample, two's complement.
- out_valid / out_ready  out / in  1 / 1  output sample handshake.
- out_real, out_imag  out  32 / 32  output bin X[k], natural order.
- out_last  out  1  high with bin 31.
- busy  out  1  high in COMPUTE and UNLOAD.
- bf_din0_real, bf_din0_imag, bf_din1_real, bf_din1_imag  out  32 each  butterfly operands.
- bf_w_real, bf_w_imag  out  32 / 32  twiddle W32^k.
- bf_dout0_real, bf_dout0_imag, bf_dout1_real, bf_dout1_imag  in  32 each  butterfly results; combinational in the same cycle.

## Operation
- Buffer: 32 × (real, imag) 32-bit registers. Not reset; contents are undefined until loaded.
- FSM states: LOAD → COMPUTE → UNLOAD → LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted sample n (n = 0..31, from a 5-bit counter) is written to buf[bitrev5(n)].
  - After sample 31 is accepted, go to COMPUTE with stage s=0 and b=0.
- COMPUTE:
  - in_ready=0.
  - Per cycle, for stage s (0..4) and butterfly b (0..15):
    - h = 2^s, pos = b & (h-1), a0 = (b>>s)·2h + pos, a1 = a0 + h, k = pos << (4-s).
  - bf_din0 = buf[a0], bf_din1 = buf[a1], bf_w = TW[k].
  - On the clock edge: buf[a0] ← bf_dout0 and buf[a1] ← bf_dout1.
  - b wraps 15→0 and increments s. After s=4, b=15, go to UNLOAD.
- UNLOAD:
  - out_valid=1, out = buf[j] for j = 0..31.
  - j advances only when out_valid && out_ready.
  - out_last = (j == 31). After bin 31 is accepted, return to LOAD.
- Outside COMPUTE: bf_din*, bf_w* are driven to 0, so the combinational butterfly path is quiet.
- Arithmetic: no rounding or scaling is done here. The butterfly owns the wrap-around 32-bit arithmetic and any TW_FRAC rescale.
- Twiddle ROM contents:
  - TW[k] = round(2^TW_FRAC · cos(2πk/32)), −round(2^TW_FRAC · sin(2πk/32)), for k = 0..15.
  - TW[0] = (2^TW_FRAC, 0); TW[8] = (0, −2^TW_FRAC).

## Timing
- Reset values: state=LOAD, all counters 0, in_ready=1, out_valid=0, out_last=0, busy=0, out_real/out_imag=0, bf_* outputs=0.
- in_ready becomes 1 combinationally in the first cycle after rst_n deasserts.
- Load: 32 accepted beats, no bubbles required; in_valid gaps are allowed.
- Compute: exactly 80 cycles. busy rises the cycle after the 32nd input acceptance.
- First out_valid: cycle 81 after the last input acceptance.
- Unload: 32 cycles minimum. out_ready low stalls with out_real/imag/last held stable.
- in_valid during COMPUTE or UNLOAD is ignored (in_ready=0). Samples are not buffered.
- out_ready is ignored outside UNLOAD.
- Back-to-back frames: LOAD is re-entered the cycle after bin 31 is accepted, with in_ready=1 that same cycle.
- Reset mid-frame (any state): immediately return to the reset values. The partial frame is discarded, and the next frame starts at n=0.

## Structure
- Shared package fft32_pkg holds:
  - N=32, LOG2N=5, DW=32.
  - the bitrev5 function.
  - the 16-entry twiddle constant arrays, parameterised by TW_FRAC.
- One sub-module, fft32_twiddle_rom: combinational, 4-bit k in, 32-bit re/im out. The butterfly itself is instantiated outside this block.

## Test plan
- Impulse, butterfly_32b connected, input x[0]=(100,0) and all others 0 → all 32 outputs (100,0). This result is independent of the twiddle format.
- Constant, golden butterfly model with products >>TW_FRAC, input x[n]=(1,0) for all n → X[0]=(32,0) and X[1..31]=(0,0). out_last is high only on beat 32.
- Address/twiddle trace: load 32 samples, then check per COMPUTE cycle:
  - s=2, b=5 → a0=9, a1=13, k=4, bf_w=(11585, −11585) for TW_FRAC=14.
  - s=4, b=15 → a0=15, a1=31, k=15.
- Backpressure: hold out_ready low for 10 cycles at j=3 → out stays X[3], then the remaining 29 bins arrive in order and busy drops after bin 31.
- Input gating: hold in_valid high throughout COMPUTE → in_ready=0 and the buffer is unchanged. The next frame loads correctly only after UNLOAD completes.
- Reset at COMPUTE s=2, b=7 → all outputs return to reset values immediately. A fresh impulse frame of (5,0) then yields all outputs (5,0).

Source files
------------

// File: rtl/fft32_pkg.sv
// Shared constants, state encoding and twiddle helpers for the 32-point
// in-place radix-2 DIT FFT sequencer.
package fft32_pkg;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int DW    = 32;
    localparam int NTW   = N / 2;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } seq_state_t;

    function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] n);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = n[LOG2N-1-i];
        end
        return r;
    endfunction

    // First-quadrant cos(2*pi*i/32) in Q30; every twiddle folds onto one of these.
    function automatic longint cos_q30(input int idx);
        case (idx)
            0:       return 64'sd1073741824;
            1:       return 64'sd1053110176;
            2:       return 64'sd992008094;
            3:       return 64'sd892783698;
            4:       return 64'sd759250125;
            5:       return 64'sd596539403;
            6:       return 64'sd410903207;
            7:       return 64'sd209476638;
            default: return 64'sd0;
        endcase
    endfunction

    // Round-half-away-from-zero rescale from Q30 down to `frac` fractional bits.
    function automatic longint q30_rescale(input longint v, input int frac);
        longint mag;
        longint r;
        int     sh;
        mag = (v < 0) ? -v : v;
        sh  = 30 - frac;
        if (sh <= 0) begin
            r = mag;
        end else begin
            r = (mag + (longint'(1) <<< (sh - 1))) >>> sh;
        end
        return (v < 0) ? -r : r;
    endfunction

    function automatic logic [DW-1:0] tw_re(input int k, input int frac);
        longint c;
        c = (k <= NTW / 2) ? cos_q30(k) : -cos_q30(NTW - k);
        return DW'(q30_rescale(c, frac));
    endfunction

    // Imaginary part is -sin, using sin(x) = cos(pi/2 - x) over the half circle.
    function automatic logic [DW-1:0] tw_im(input int k, input int frac);
        longint s;
        s = (k <= NTW / 2) ? cos_q30(NTW / 2 - k) : cos_q30(k - NTW / 2);
        return DW'(q30_rescale(-s, frac));
    endfunction

endpackage

// File: rtl/fft32_twiddle_rom.sv
// Combinational 16-entry twiddle ROM: W32^k in Q(31-TW_FRAC).TW_FRAC.
module fft32_twiddle_rom
    import fft32_pkg::*;
#(
    parameter int TW_FRAC = 14
) (
    input  logic [3:0]    k,
    output logic [DW-1:0] w_re,
    output logic [DW-1:0] w_im
);

    logic [DW-1:0] re_tab [NTW];
    logic [DW-1:0] im_tab [NTW];

    genvar gi;
    generate
        for (gi = 0; gi < NTW; gi++) begin : g_tw
            assign re_tab[gi] = tw_re(gi, TW_FRAC);
            assign im_tab[gi] = tw_im(gi, TW_FRAC);
        end
    endgenerate

    assign w_re = re_tab[k];
    assign w_im = im_tab[k];

endmodule

// File: rtl/fft32_bfly_sequencer.sv
// In-place 32-point radix-2 DIT FFT sequencer: bit-reversed load, 80 butterfly
// cycles through an external combinational butterfly, natural-order unload.
module fft32_bfly_sequencer
    import fft32_pkg::*;
#(
    parameter int TW_FRAC = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_imag,
    output logic          out_last,
    output logic          busy,
    output logic [DW-1:0] bf_din0_real,
    output logic [DW-1:0] bf_din0_imag,
    output logic [DW-1:0] bf_din1_real,
    output logic [DW-1:0] bf_din1_imag,
    output logic [DW-1:0] bf_w_real,
    output logic [DW-1:0] bf_w_imag,
    input  logic [DW-1:0] bf_dout0_real,
    input  logic [DW-1:0] bf_dout0_imag,
    input  logic [DW-1:0] bf_dout1_real,
    input  logic [DW-1:0] bf_dout1_imag
);

    seq_state_t       state_reg;
    logic [LOG2N-1:0] n_reg;
    logic [LOG2N-1:0] j_reg;
    logic [2:0]       s_reg;
    logic [3:0]       b_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic             busy_reg;

    logic [DW-1:0] buf_re_reg [N];
    logic [DW-1:0] buf_im_reg [N];

    logic             in_fire;
    logic             out_fire;
    logic             computing;
    logic             last_bfly;
    logic [LOG2N-1:0] b_ext;
    logic [LOG2N-1:0] h;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] a0;
    logic [LOG2N-1:0] a1;
    logic [3:0]       k;
    logic [DW-1:0]    rom_w_re;
    logic [DW-1:0]    rom_w_im;

    assign in_fire   = in_ready_reg && in_valid;
    assign out_fire  = out_valid_reg && out_ready;
    assign computing = (state_reg == ST_COMPUTE);
    assign last_bfly = (s_reg == 3'(LOG2N - 1)) && (b_reg == 4'hF);

    // Butterfly b of stage s pairs a0 and a0+h inside group b>>s of width 2h.
    always_comb begin
        b_ext = {1'b0, b_reg};
        h     = 5'd1 << s_reg;
        pos   = b_ext & (h - 5'd1);
        a0    = ((b_ext >> s_reg) << (s_reg + 3'd1)) + pos;
        a1    = a0 + h;
        k     = 4'(pos << (3'd4 - s_reg));
    end

    fft32_twiddle_rom #(
        .TW_FRAC (TW_FRAC)
    ) u_twiddle_rom (
        .k    (k),
        .w_re (rom_w_re),
        .w_im (rom_w_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_LOAD;
            n_reg         <= '0;
            j_reg         <= '0;
            s_reg         <= '0;
            b_reg         <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (in_fire) begin
                        n_reg <= n_reg + 5'd1;
                        if (n_reg == 5'(N - 1)) begin
                            state_reg    <= ST_COMPUTE;
                            in_ready_reg <= 1'b0;
                            busy_reg     <= 1'b1;
                            s_reg        <= '0;
                            b_reg        <= '0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    b_reg <= b_reg + 4'd1;
                    if (b_reg == 4'hF) begin
                        s_reg <= s_reg + 3'd1;
                    end
                    if (last_bfly) begin
                        state_reg     <= ST_UNLOAD;
                        s_reg         <= '0;
                        j_reg         <= '0;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= 1'b0;
                    end
                end
                ST_UNLOAD: begin
                    if (out_fire) begin
                        if (j_reg == 5'(N - 1)) begin
                            state_reg     <= ST_LOAD;
                            j_reg         <= '0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            in_ready_reg  <= 1'b1;
                        end else begin
                            j_reg        <= j_reg + 5'd1;
                            out_last_reg <= (j_reg == 5'(N - 2));
                        end
                    end
                end
                default: begin
                    state_reg <= ST_LOAD;
                end
            endcase
        end
    end

    // Sample buffer holds no reset: a full load overwrites every entry anyway.
    always_ff @(posedge clk) begin
        if (computing) begin
            buf_re_reg[a0] <= bf_dout0_real;
            buf_im_reg[a0] <= bf_dout0_imag;
            buf_re_reg[a1] <= bf_dout1_real;
            buf_im_reg[a1] <= bf_dout1_imag;
        end else if (in_fire) begin
            buf_re_reg[bitrev5(n_reg)] <= in_real;
            buf_im_reg[bitrev5(n_reg)] <= in_imag;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

    assign out_real = out_valid_reg ? buf_re_reg[j_reg] : '0;
    assign out_imag = out_valid_reg ? buf_im_reg[j_reg] : '0;

    // Operands are forced to zero outside COMPUTE to keep the butterfly quiet.
    assign bf_din0_real = computing ? buf_re_reg[a0] : '0;
    assign bf_din0_imag = computing ? buf_im_reg[a0] : '0;
    assign bf_din1_real = computing ? buf_re_reg[a1] : '0;
    assign bf_din1_imag = computing ? buf_im_reg[a1] : '0;
    assign bf_w_real    = computing ? rom_w_re : '0;
    assign bf_w_imag    = computing ? rom_w_im : '0;

endmodule
